// File: rtl/i2c_byte_if.sv
// Purpose: groups the host-side byte request/response signals and the
//          single-bit command channel to i2c_bit into one bundle.
// Signals:
//   host  -> ctrl : start, stop, read, write, ack_in, din[7:0]
//   ctrl  -> host : cmd_ack, ack_out, dout[7:0], i2c_busy, i2c_al
//   ctrl  -> bit  : core_cmd[3:0], core_txd
//   bit   -> ctrl : core_ack, core_rxd, core_busy, core_al
// Modports: slave  = byte controller view
//           master = host plus bit-controller view (driver side)
interface i2c_byte_if;
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
    logic       cmd_ack;
    logic       ack_out;
    logic [7:0] dout;
    logic       i2c_busy;
    logic       i2c_al;
    logic [3:0] core_cmd;
    logic       core_txd;
    logic       core_ack;
    logic       core_rxd;
    logic       core_busy;
    logic       core_al;

    modport slave (
        input  start, stop, read, write, ack_in, din,
        input  core_ack, core_rxd, core_busy, core_al,
        output cmd_ack, ack_out, dout, i2c_busy, i2c_al,
        output core_cmd, core_txd
    );

    modport master (
        output start, stop, read, write, ack_in, din,
        output core_ack, core_rxd, core_busy, core_al,
        input  cmd_ack, ack_out, dout, i2c_busy, i2c_al,
        input  core_cmd, core_txd
    );
endinterface

// File: rtl/i2c_byte.sv
// Purpose: byte-level I2C command controller. Turns one host byte request
//          (optional START, READ or WRITE of 8 bits plus the ACK bit,
//          optional STOP) into the per-bit command stream for i2c_bit.
// Ports:
//   clk     : system clock
//   nReset  : asynchronous active-low reset
//   bus     : i2c_byte_if.slave (host request/response + bit-controller link)
// Build option:
//   I2C_BYTE_LSB_FIRST_EN : when defined, data bits are sent and received
//                           LSB-first; counter, ACK handling and timing are
//                           unchanged. Undefined gives standard MSB-first.

`ifndef I2C_CMD_NOP
`define I2C_CMD_NOP   4'b0000
`define I2C_CMD_START 4'b0001
`define I2C_CMD_STOP  4'b0010
`define I2C_CMD_WRITE 4'b0100
`define I2C_CMD_READ  4'b1000
`endif

module i2c_byte (
    input  logic       clk,
    input  logic       nReset,
    i2c_byte_if.slave  bus
);

    localparam logic [3:0] CMD_NOP   = `I2C_CMD_NOP;
    localparam logic [3:0] CMD_START = `I2C_CMD_START;
    localparam logic [3:0] CMD_STOP  = `I2C_CMD_STOP;
    localparam logic [3:0] CMD_WRITE = `I2C_CMD_WRITE;
    localparam logic [3:0] CMD_READ  = `I2C_CMD_READ;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_READ,
        ST_WRITE,
        ST_ACK,
        ST_STOP
    } state_e;

    state_e     state_q;
    logic [3:0] core_cmd_q;
    logic       core_txd_q;
    logic       cmd_ack_q;
    logic       ack_out_q;
    logic [7:0] sr_q;
    logic [2:0] cnt_q;
    logic       start_q;
    logic       stop_q;
    logic       read_q;
    logic       write_q;
    logic       ack_in_q;

    // Bit-order selection: first bit from din, current/next bit from sr, shift.
    logic       din_first_c;
    logic       sr_first_c;
    logic       sr_next_c;
    logic [7:0] sr_shift_c;

`ifdef I2C_BYTE_LSB_FIRST_EN
    assign din_first_c = bus.din[0];
    assign sr_first_c  = sr_q[0];
    assign sr_next_c   = sr_q[1];
    assign sr_shift_c  = {bus.core_rxd, sr_q[7:1]};
`else
    assign din_first_c = bus.din[7];
    assign sr_first_c  = sr_q[7];
    assign sr_next_c   = sr_q[6];
    assign sr_shift_c  = {sr_q[6:0], bus.core_rxd};
`endif

    // Registered cmd_ack masks the still-held host flags during the done pulse.
    logic go_c;
    assign go_c = (bus.start | bus.stop | bus.read | bus.write) & ~cmd_ack_q;

    // Sequencer: one core command outstanding, advanced on each core_ack.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            core_cmd_q <= CMD_NOP;
            core_txd_q <= 1'b0;
            cmd_ack_q  <= 1'b0;
            ack_out_q  <= 1'b0;
            sr_q       <= 8'h00;
            cnt_q      <= 3'd0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            ack_in_q   <= 1'b0;
        end else begin
            cmd_ack_q <= 1'b0;
            if (bus.core_al) begin
                // Arbitration loss aborts everything, even a coincident core_ack.
                state_q    <= ST_IDLE;
                core_cmd_q <= CMD_NOP;
                cnt_q      <= 3'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (go_c) begin
                            start_q  <= bus.start;
                            stop_q   <= bus.stop;
                            read_q   <= bus.read;
                            write_q  <= bus.write;
                            ack_in_q <= bus.ack_in;
                            sr_q     <= bus.din;
                            cnt_q    <= 3'd7;
                            if (bus.start) begin
                                state_q    <= ST_START;
                                core_cmd_q <= CMD_START;
                            end else if (bus.read) begin
                                state_q    <= ST_READ;
                                core_cmd_q <= CMD_READ;
                            end else if (bus.write) begin
                                state_q    <= ST_WRITE;
                                core_cmd_q <= CMD_WRITE;
                                core_txd_q <= din_first_c;
                            end else begin
                                state_q    <= ST_STOP;
                                core_cmd_q <= CMD_STOP;
                            end
                        end
                    end

                    ST_START: begin
                        if (bus.core_ack) begin
                            if (read_q) begin
                                state_q    <= ST_READ;
                                core_cmd_q <= CMD_READ;
                            end else begin
                                state_q    <= ST_WRITE;
                                core_cmd_q <= CMD_WRITE;
                                core_txd_q <= sr_first_c;
                            end
                        end
                    end

                    ST_READ, ST_WRITE: begin
                        if (bus.core_ack) begin
                            sr_q <= sr_shift_c;
                            if (cnt_q != 3'd0) begin
                                cnt_q      <= 3'(cnt_q - 3'd1);
                                core_txd_q <= sr_next_c;
                            end else begin
                                // 9th bit: master drives ACK after a read, samples it after a write.
                                state_q <= ST_ACK;
                                if (state_q == ST_READ) begin
                                    core_cmd_q <= CMD_WRITE;
                                    core_txd_q <= ack_in_q;
                                end else begin
                                    core_cmd_q <= CMD_READ;
                                end
                            end
                        end
                    end

                    ST_ACK: begin
                        if (bus.core_ack) begin
                            ack_out_q  <= bus.core_rxd;
                            core_txd_q <= 1'b1;
                            if (stop_q) begin
                                state_q    <= ST_STOP;
                                core_cmd_q <= CMD_STOP;
                            end else begin
                                state_q    <= ST_IDLE;
                                core_cmd_q <= CMD_NOP;
                                cmd_ack_q  <= 1'b1;
                            end
                        end
                    end

                    ST_STOP: begin
                        if (bus.core_ack) begin
                            state_q    <= ST_IDLE;
                            core_cmd_q <= CMD_NOP;
                            cmd_ack_q  <= 1'b1;
                        end
                    end

                    default: begin
                        state_q    <= ST_IDLE;
                        core_cmd_q <= CMD_NOP;
                    end
                endcase
            end
        end
    end

    assign bus.core_cmd = core_cmd_q;
    assign bus.core_txd = core_txd_q;
    assign bus.cmd_ack  = cmd_ack_q;
    assign bus.ack_out  = ack_out_q;
    assign bus.dout     = sr_q;
    assign bus.i2c_busy = bus.core_busy;
    assign bus.i2c_al   = bus.core_al;

endmodule

// File: tb/tb_i2c_byte.sv
// Purpose: directed self-checking bench for i2c_byte. A small bit-controller
//          model acknowledges each core command four clocks after it
//          appears, echoes core_txd on WRITE and returns a scripted bit
//          pattern on READ.
module tb_i2c_byte;

    localparam logic [3:0] NOP   = 4'b0000;
    localparam logic [3:0] START = 4'b0001;
    localparam logic [3:0] STOP  = 4'b0010;
    localparam logic [3:0] WRITE = 4'b0100;
    localparam logic [3:0] READ  = 4'b1000;

    logic clk;
    logic nReset;

    i2c_byte_if bus ();

    i2c_byte dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Bit-controller model state
    logic [3:0]  cmd_log [0:31];
    logic        txd_log [0:31];
    int          n_log = 0;
    logic [15:0] rd_pat = 16'h0000;
    int          rd_idx = 0;
    bit          model_en = 1'b1;
    int          al_at = -1;
    bit          al_pending = 1'b0;
    logic        al_seen = 1'b0;
    logic [3:0]  post_al_cmd = 4'hF;
    logic        post_al_ack = 1'b1;
    int          n_ack = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int i);
`ifdef I2C_BYTE_LSB_FIRST_EN
        return b[3'(i)];
`else
        return b[3'(7 - i)];
`endif
    endfunction

    // Count done pulses (one count per cycle high)
    initial begin
        forever begin
            @(negedge clk);
            if (bus.cmd_ack === 1'b1) n_ack++;
        end
    end

    // Bit-controller model
    initial begin
        int   cur;
        logic rxd;
        bus.core_ack  = 1'b0;
        bus.core_rxd  = 1'b0;
        bus.core_al   = 1'b0;
        bus.core_busy = 1'b0;
        forever begin
            @(negedge clk);
            bus.core_ack = 1'b0;
            if (al_pending) begin
                post_al_cmd = bus.core_cmd;
                post_al_ack = bus.cmd_ack;
                bus.core_al = 1'b0;
                al_pending  = 1'b0;
            end
            if (model_en && nReset && bus.core_cmd != NOP && n_log < 32) begin
                cur          = n_log;
                cmd_log[cur] = bus.core_cmd;
                txd_log[cur] = bus.core_txd;
                n_log++;
                repeat (3) @(negedge clk);
                if (model_en && nReset) begin
                    rxd = 1'b0;
                    if (cmd_log[cur] == READ) begin
                        rxd = (rd_idx < 16) ? rd_pat[4'(15 - rd_idx)] : 1'b1;
                        rd_idx++;
                    end else if (cmd_log[cur] == WRITE) begin
                        rxd = bus.core_txd;
                    end
                    bus.core_rxd = rxd;
                    bus.core_ack = 1'b1;
                    if (cur == al_at) begin
                        bus.core_al = 1'b1;
                        al_pending  = 1'b1;
                        #1 al_seen  = bus.i2c_al;
                    end
                end
            end
        end
    end

    task automatic set_flags(input logic s, input logic w, input logic r,
                             input logic p, input logic a, input logic [7:0] d);
        bus.start  = s;
        bus.write  = w;
        bus.read   = r;
        bus.stop   = p;
        bus.ack_in = a;
        bus.din    = d;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.cmd_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic new_seq(input logic [15:0] pat);
        n_log  = 0;
        rd_idx = 0;
        rd_pat = pat;
    endtask

    initial begin
        int base;
        bit hit;
        nReset = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd",     32'(bus.core_cmd), 32'(NOP));
        check("rst_cmd_ack", 32'(bus.cmd_ack),  32'd0);
        check("rst_ack_out", 32'(bus.ack_out),  32'd0);
        check("rst_dout",    32'(bus.dout),     32'h00);
        check("rst_txd",     32'(bus.core_txd), 32'd0);
        nReset = 1'b1;
        @(negedge clk);

        // Busy passthrough
        bus.core_busy = 1'b1;
        #1 check("busy_hi", 32'(bus.i2c_busy), 32'd1);
        bus.core_busy = 1'b0;
        #1 check("busy_lo", 32'(bus.i2c_busy), 32'd0);

        // START + WRITE A5 + STOP
        new_seq(16'h0000);
        base = n_ack;
        @(negedge clk);
        set_flags(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
        wait_done("A_done", 200);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("A_ncmd", 32'(n_log), 32'd11);
        check("A_c0", 32'(cmd_log[0]), 32'(START));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("A_wc%0d", i), 32'(cmd_log[1 + i]), 32'(WRITE));
            check($sformatf("A_tx%0d", i), 32'(txd_log[1 + i]), 32'(exp_bit(8'hA5, i)));
        end
        check("A_c9",    32'(cmd_log[9]),  32'(READ));
        check("A_c10",   32'(cmd_log[10]), 32'(STOP));
        check("A_ackout",32'(bus.ack_out), 32'd0);
        check("A_dout",  32'(bus.dout),    32'hA5);
        check("A_pulses",32'(n_ack - base),32'd1);
        check("A_nop",   32'(bus.core_cmd),32'(NOP));

        // READ with NACK, no start/stop; slave returns 0,1,1,0,1,1,0,0
        new_seq(16'h6C00);
        base = n_ack;
        set_flags(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        wait_done("B_done", 200);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (10) @(negedge clk);
        check("B_ncmd", 32'(n_log), 32'd9);
        for (int i = 0; i < 8; i++)
            check($sformatf("B_rc%0d", i), 32'(cmd_log[i]), 32'(READ));
        check("B_ackcmd", 32'(cmd_log[8]), 32'(WRITE));
        check("B_acktxd", 32'(txd_log[8]), 32'd1);
`ifdef I2C_BYTE_LSB_FIRST_EN
        check("B_dout", 32'(bus.dout), 32'h36);
`else
        check("B_dout", 32'(bus.dout), 32'h6C);
`endif
        check("B_ackout", 32'(bus.ack_out), 32'd1);
        check("B_pulses", 32'(n_ack - base), 32'd1);

        // Reset mid-WRITE after 3 core_acks
        new_seq(16'h0000);
        set_flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        @(negedge clk);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_log >= 4) begin
                hit = 1'b1;
                break;
            end
        end
        check("R_reach", 32'(hit), 32'd1);
        model_en = 1'b0;
        nReset   = 1'b0;
        #1;
        check("R_cmd",     32'(bus.core_cmd), 32'(NOP));
        check("R_cmd_ack", 32'(bus.cmd_ack),  32'd0);
        check("R_dout",    32'(bus.dout),     32'h00);
        check("R_ackout",  32'(bus.ack_out),  32'd0);
        repeat (5) @(negedge clk);
        nReset   = 1'b1;
        model_en = 1'b1;
        new_seq(16'h0000);
        base = n_ack;
        set_flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81);
        @(negedge clk);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        wait_done("R2_done", 200);
        repeat (3) @(negedge clk);
        check("R2_ncmd", 32'(n_log), 32'd9);
        check("R2_c0",   32'(cmd_log[0]), 32'(WRITE));
        check("R2_tx0",  32'(txd_log[0]), 32'(exp_bit(8'h81, 0)));
        check("R2_dout", 32'(bus.dout), 32'h81);
        check("R2_pulses", 32'(n_ack - base), 32'd1);

        // Host holds write through completion
        new_seq(16'h0000);
        base = n_ack;
        set_flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
        wait_done("C_done", 200);
        check("C_nop_pulse", 32'(bus.core_cmd), 32'(NOP));
        @(negedge clk);
        check("C_pulse_w", 32'(bus.cmd_ack),  32'd0);
        check("C_no_retrig", 32'(bus.core_cmd), 32'(NOP));
        @(negedge clk);
        check("C_restart", 32'(bus.core_cmd), 32'(WRITE));
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        wait_done("C2_done", 200);
        repeat (20) @(negedge clk);
        check("C_pulses", 32'(n_ack - base), 32'd2);
        check("C_ncmd",   32'(n_log), 32'd18);
        check("C_idle",   32'(bus.core_cmd), 32'(NOP));
        check("C_dout",   32'(bus.dout), 32'h3C);

        // Arbitration lost on the 5th WRITE, coincident with core_ack
        new_seq(16'h0000);
        base        = n_ack;
        al_at       = 4;
        al_seen     = 1'b0;
        post_al_cmd = 4'hF;
        post_al_ack = 1'b1;
        set_flags(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB4);
        @(negedge clk);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (40) @(negedge clk);
        al_at = -1;
        check("D_al_seen", 32'(al_seen),     32'd1);
        check("D_post_cmd",32'(post_al_cmd), 32'(NOP));
        check("D_post_ack",32'(post_al_ack), 32'd0);
        check("D_ncmd",    32'(n_log),       32'd5);
        check("D_pulses",  32'(n_ack - base),32'd0);
        check("D_dout",    32'(bus.dout),    32'h4B);
        check("D_ackout",  32'(bus.ack_out), 32'd0);

        // Write 01: bit order
        new_seq(16'h0000);
        set_flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        @(negedge clk);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        wait_done("E_done", 200);
        for (int i = 0; i < 8; i++)
            check($sformatf("E_tx%0d", i), 32'(txd_log[i]), 32'(exp_bit(8'h01, i)));
        check("E_dout", 32'(bus.dout), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_byte.md
Name: i2c_byte

Overview:
Byte-level command controller sitting directly upstream of i2c_bit.
- Accepts byte requests (START / WRITE / READ / ACK / STOP flags plus an 8-bit data byte) from the register/host layer.
- Sequences them into the single-bit command stream i2c_bit consumes: cmd, din, cmd_ack, dout, al.
- Shifts data MSB-first, handles the 9th (ACK) bit, and reports completion, the received byte, the received ACK and arbitration loss back to the host.

Parameters:
none (command encodings are the shared `I2C_CMD_* defines: NOP 4'b0000, START 4'b0001, STOP 4'b0010, WRITE 4'b0100, READ 4'b1000)

Ports:
clk  input  1  system clock, single domain
nReset  input  1  asynchronous active-low reset
start  input  1  generate (repeated) START before the byte
stop  input  1  generate STOP after the byte
read  input  1  read a byte from the slave
write  input  1  write din to the slave
ack_in  input  1  ACK bit driven after a read (0 = ACK, 1 = NACK)
din  input  8  byte to transmit
cmd_ack  output  1  one-cycle pulse: requested sequence complete
ack_out  output  1  ACK bit sampled in the 9th clock
dout  output  8  received byte (shift register contents)
i2c_busy  output  1  bus busy, passthrough of bit-controller busy
i2c_al  output  1  arbitration lost, passthrough of bit-controller al
core_cmd  output  4  command to i2c_bit cmd
core_txd  output  1  bit to i2c_bit din
core_ack  input  1  i2c_bit cmd_ack
core_rxd  input  1  i2c_bit dout
core_busy  input  1  i2c_bit busy
core_al  input  1  i2c_bit al

Behaviour:
- Reset (nReset low, asynchronous) drives:
  - state=IDLE; core_cmd=NOP; core_txd=0; cmd_ack=0; ack_out=0; sr=8'h00; bit counter=0; latched flags=0.
- dout=sr at all times. i2c_busy=core_busy. i2c_al=core_al. All other outputs are registered.
- go = (start|stop|read|write) & ~cmd_ack. Requests are sampled only in IDLE.
- On go: latch start/stop/read/write/ack_in into internal regs; sr<=din; cnt<=7. Next state by priority:
  - start -> START, core_cmd=START
  - else read -> READ, core_cmd=READ
  - else write -> WRITE, core_cmd=WRITE, core_txd=din[7]
  - else STOP, core_cmd=STOP
- Host flag changes after go are ignored until the next IDLE.
- core_cmd is held stable until the cycle core_ack=1. In that same cycle it is replaced by the next command, or NOP on return to IDLE. Exactly one core_ack is consumed per issued command.
- START + core_ack:
  - latched read -> READ, core_cmd=READ
  - else -> WRITE, core_cmd=WRITE, core_txd=sr[7]
- READ/WRITE + core_ack: sr<={sr[6:0],core_rxd}.
  - cnt!=0: cnt<=cnt-1; reissue the same command; core_txd=sr[6] (next bit).
  - cnt==0: go to ACK.
    - After a read: core_cmd=WRITE, core_txd=latched ack_in.
    - After a write: core_cmd=READ.
- ACK + core_ack: ack_out<=core_rxd; core_txd<=1.
  - latched stop -> STOP, core_cmd=STOP
  - else -> IDLE, cmd_ack=1, core_cmd=NOP
- STOP + core_ack: IDLE, cmd_ack=1, core_cmd=NOP.
- cmd_ack is high exactly one cycle, then deasserts. The ~cmd_ack term in go prevents the still-held host flags from retriggering a sequence in that cycle.
- Latency: cmd_ack rises the cycle after the last core_ack of the sequence.
  - write+stop with no start = 8 + 1 + 1 = 10 core commands.
  - start+write+stop = 11 core commands.
- core_al=1 in any state:
  - next cycle: state=IDLE, core_cmd=NOP, cmd_ack=0, cnt=0.
  - sr and ack_out keep their last values.
  - al takes priority over a simultaneous core_ack.
- stop alone (no read/write) issues only STOP.
- read and write both set: read wins.
- core_ack while in IDLE is ignored.

Optional Feature:
Macro I2C_BYTE_LSB_FIRST_EN.
- Defined: bit order is reversed for non-standard peripherals.
  - core_txd takes sr[0] / sr[1].
  - shift is sr<={core_rxd,sr[7:1]}.
  - dout therefore holds the received byte LSB-first aligned.
- Undefined: standard MSB-first behaviour as above.
- Counter, ACK handling and timing are identical in both builds.

Test Plan:
- Reset mid-WRITE (after 3 core_acks), nReset pulsed low -> core_cmd=NOP immediately (async); all outputs at reset values; the next go starts cleanly.
- start=1, write=1, stop=1, din=8'hA5; bit-model acks each command after 4 clk with core_rxd=0 on the ACK bit -> core_cmd sequence START, 8×WRITE with core_txd 1,0,1,0,0,1,0,1, READ, STOP; ack_out=0; one cmd_ack pulse; core_cmd=NOP after.
- read=1, ack_in=1, no start/stop; model returns bits 0,1,1,0,1,1,0,0 -> 8×READ, then WRITE with core_txd=1; dout=8'h6C; cmd_ack pulse; no STOP issued.
- Host holds write=1 through completion -> exactly one cmd_ack pulse; a new sequence starts only on the cycle after the pulse. With flags dropped, no retrigger.
- core_al=1 during the 5th WRITE, coincident with core_ack -> IDLE next cycle, core_cmd=NOP, no cmd_ack, i2c_al visible same cycle.
- With I2C_BYTE_LSB_FIRST_EN defined, write din=8'h01 -> first core_txd=1, remaining seven 0.
